// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : cpu_pkg                                                       |
// | Purpose    : Shared constants for the RISC CPU controller: state encoding, |
// |              opcode/op values, one-hot register-select and write-back mux  |
// |              codes, and small instruction-classification helpers.          |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package cpu_pkg;

    // Controller state encoding. HALT is only reachable when the illegal
    // instruction trap is built in.
    localparam logic [3:0] ST_WAIT   = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_WR_IMM = 4'd2;
    localparam logic [3:0] ST_GET_A  = 4'd3;
    localparam logic [3:0] ST_GET_B  = 4'd4;
    localparam logic [3:0] ST_ALU    = 4'd5;
    localparam logic [3:0] ST_WR_REG = 4'd6;
    localparam logic [3:0] ST_STAT   = 4'd7;
    localparam logic [3:0] ST_HALT   = 4'd8;

    // Opcode / op fields from the instruction decoder.
    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    // One-hot register-file select.
    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    // One-hot write-back mux select.
    localparam logic [3:0] VSEL_NONE   = 4'b0000;
    localparam logic [3:0] VSEL_MDATA  = 4'b0001;
    localparam logic [3:0] VSEL_SXIMM8 = 4'b0010;
    localparam logic [3:0] VSEL_PC     = 4'b0100;
    localparam logic [3:0] VSEL_C      = 4'b1000;

    // True for the six instructions the controller knows how to sequence.
    function automatic logic is_legal(input logic [2:0] opc, input logic [1:0] op);
        logic r;
        r = 1'b0;
        if (opc == OPC_MOV) begin
            r = (op == OP_MOV_IMM) || (op == OP_MOV_REG);
        end else if (opc == OPC_ALU) begin
            r = 1'b1;
        end
        return r;
    endfunction

    // First state after DECODE for a legal instruction. Only the MOV-immediate
    // and the single-operand forms (MOV Rd,Rm and MVN) skip GET_A.
    function automatic logic [3:0] first_state(input logic [2:0] opc, input logic [1:0] op);
        logic [3:0] r;
        r = ST_GET_A;
        if (opc == OPC_MOV) begin
            r = (op == OP_MOV_IMM) ? ST_WR_IMM : ST_GET_B;
        end else if (op == OP_MVN) begin
            r = ST_GET_B;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_ctrl_fsm_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface  : cpu_ctrl_fsm_if                                               |
// | Purpose    : Bundles the decoder handshake (s, opcode, op) and the         |
// |              datapath control word driven by cpu_ctrl_fsm.                 |
// | Modports   : master - decoder/datapath side (drives s/opcode/op)           |
// |              slave  - controller side (drives w, control word, icount)     |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
interface cpu_ctrl_fsm_if #(
    parameter int RETIRE_W = 16
) ();
    logic                s;
    logic [2:0]          opcode;
    logic [1:0]          op;
    logic                w;
    logic [2:0]          nsel;
    logic [3:0]          vsel;
    logic                loada;
    logic                loadb;
    logic                loadc;
    logic                loads;
    logic                write;
    logic                asel;
    logic                bsel;
    logic                done;
    logic                illegal;
    logic [RETIRE_W-1:0] icount;

    modport master (
        output s, opcode, op,
        input  w, nsel, vsel, loada, loadb, loadc, loads, write,
               asel, bsel, done, illegal, icount
    );

    modport slave (
        input  s, opcode, op,
        output w, nsel, vsel, loada, loadb, loadc, loads, write,
               asel, bsel, done, illegal, icount
    );
endinterface
`default_nettype wire

// File: rtl/cpu_ctrl_outdec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : cpu_ctrl_outdec                                               |
// | Purpose    : Combinational Moore output decode: registered state plus the  |
// |              registered (captured) opcode/op -> datapath control word.     |
// | Ports      : state_i, opcode_i, op_i          registered controller state  |
// |              w_o .. illegal_o                 datapath control word        |
// | Config     : CPU_ILLEGAL_TRAP_EN enables the HALT decode (illegal_o=1).    |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module cpu_ctrl_outdec
    import cpu_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic [2:0] opcode_i,
    input  logic [1:0] op_i,
    output logic       w_o,
    output logic [2:0] nsel_o,
    output logic [3:0] vsel_o,
    output logic       loada_o,
    output logic       loadb_o,
    output logic       loadc_o,
    output logic       loads_o,
    output logic       write_o,
    output logic       asel_o,
    output logic       bsel_o,
    output logic       done_o,
    output logic       illegal_o
);

    always_comb begin
        w_o       = 1'b0;
        nsel_o    = NSEL_NONE;
        vsel_o    = VSEL_NONE;
        loada_o   = 1'b0;
        loadb_o   = 1'b0;
        loadc_o   = 1'b0;
        loads_o   = 1'b0;
        write_o   = 1'b0;
        asel_o    = 1'b0;
        bsel_o    = 1'b0;
        done_o    = 1'b0;
        illegal_o = 1'b0;
        case (state_i)
            ST_WAIT: w_o = 1'b1;
            ST_WR_IMM: begin
                nsel_o  = NSEL_RN;
                vsel_o  = VSEL_SXIMM8;
                write_o = 1'b1;
                done_o  = 1'b1;
            end
            ST_GET_A: begin
                nsel_o  = NSEL_RN;
                loada_o = 1'b1;
            end
            ST_GET_B: begin
                nsel_o  = NSEL_RM;
                loadb_o = 1'b1;
            end
            ST_ALU: begin
                loadc_o = 1'b1;
                // Single-operand instructions pass B through with A forced to 0.
                asel_o  = (opcode_i == OPC_MOV) || (op_i == OP_MVN);
            end
            ST_WR_REG: begin
                nsel_o  = NSEL_RD;
                vsel_o  = VSEL_C;
                write_o = 1'b1;
                done_o  = 1'b1;
            end
            ST_STAT: begin
                loads_o = 1'b1;
                done_o  = 1'b1;
            end
`ifdef CPU_ILLEGAL_TRAP_EN
            ST_HALT: illegal_o = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : cpu_ctrl_fsm                                                  |
// | Purpose    : Moore controller for the simple RISC CPU. Captures opcode/op  |
// |              on start, sequences each instruction over several cycles and  |
// |              counts retired legal instructions.                            |
// | Ports      : clk       rising-edge clock                                   |
// |              reset_n   asynchronous active-low reset                       |
// |              bus       cpu_ctrl_fsm_if.slave (s/opcode/op in, control out) |
// | Params     : RETIRE_W  width of the wrapping retired-instruction counter   |
// | Config     : CPU_ILLEGAL_TRAP_EN - illegal instructions park in HALT until |
// |              reset; otherwise they return silently to WAIT.                |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int RETIRE_W = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    cpu_ctrl_fsm_if.slave  bus
);

    logic [3:0]          state_q,  state_d;
    logic [2:0]          opcode_q, opcode_d;
    logic [1:0]          op_q,     op_d;
    logic [RETIRE_W-1:0] icount_q, icount_d;
    logic                done;

`ifdef CPU_ILLEGAL_TRAP_EN
    localparam logic [3:0] ILLEGAL_DEST = ST_HALT;
`else
    localparam logic [3:0] ILLEGAL_DEST = ST_WAIT;
`endif

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        op_d     = op_q;
        case (state_q)
            ST_WAIT: begin
                if (bus.s) begin
                    state_d  = ST_DECODE;
                    opcode_d = bus.opcode;
                    op_d     = bus.op;
                end
            end
            ST_DECODE: begin
                if (is_legal(opcode_q, op_q)) begin
                    state_d = first_state(opcode_q, op_q);
                end else begin
                    state_d = ILLEGAL_DEST;
                end
            end
            ST_GET_A: state_d = ST_GET_B;
            ST_GET_B: begin
                // CMP only updates status; everything else goes through C.
                if ((opcode_q == OPC_ALU) && (op_q == OP_CMP)) begin
                    state_d = ST_STAT;
                end else begin
                    state_d = ST_ALU;
                end
            end
            ST_ALU:    state_d = ST_WR_REG;
            ST_WR_IMM: state_d = ST_WAIT;
            ST_WR_REG: state_d = ST_WAIT;
            ST_STAT:   state_d = ST_WAIT;
`ifdef CPU_ILLEGAL_TRAP_EN
            ST_HALT:   state_d = ST_HALT;
`endif
            default:   state_d = ST_WAIT;
        endcase
    end

    always_comb begin
        icount_d = icount_q;
        if (done) begin
            icount_d = icount_q + RETIRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_WAIT;
            opcode_q <= 3'b000;
            op_q     <= 2'b00;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            op_q     <= op_d;
            icount_q <= icount_d;
        end
    end

    cpu_ctrl_outdec u_outdec (
        .state_i   (state_q),
        .opcode_i  (opcode_q),
        .op_i      (op_q),
        .w_o       (bus.w),
        .nsel_o    (bus.nsel),
        .vsel_o    (bus.vsel),
        .loada_o   (bus.loada),
        .loadb_o   (bus.loadb),
        .loadc_o   (bus.loadc),
        .loads_o   (bus.loads),
        .write_o   (bus.write),
        .asel_o    (bus.asel),
        .bsel_o    (bus.bsel),
        .done_o    (done),
        .illegal_o (bus.illegal)
    );

    assign bus.done   = done;
    assign bus.icount = icount_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_cpu_ctrl_fsm                                               |
// | Purpose    : Self-checking bench for cpu_ctrl_fsm. A per-instruction       |
// |              reference builds the expected cycle-by-cycle control words    |
// |              from the instruction's micro-step list; a counter model       |
// |              tracks retired instructions modulo 2^RW.                      |
// | Config     : honours CPU_ILLEGAL_TRAP_EN to pick illegal-instruction model |
// | Revision   : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_cpu_ctrl_fsm;

    localparam int RW = 4;

    typedef struct packed {
        logic       w;
        logic [2:0] nsel;
        logic [3:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       write;
        logic       asel;
        logic       bsel;
        logic       done;
        logic       illegal;
    } ctrl_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    int   model_icount;
    ctrl_t exp_q[$];

    cpu_ctrl_fsm_if #(.RETIRE_W(RW)) bus ();

    cpu_ctrl_fsm #(.RETIRE_W(RW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- micro-step control words ----
    function automatic ctrl_t cw_wait();
        ctrl_t c = '0;
        c.w = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t cw_decode();
        ctrl_t c = '0;
        return c;
    endfunction
    function automatic ctrl_t cw_get_a();
        ctrl_t c = '0;
        c.nsel = 3'b001; c.loada = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t cw_get_b();
        ctrl_t c = '0;
        c.nsel = 3'b100; c.loadb = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t cw_alu(input logic a);
        ctrl_t c = '0;
        c.loadc = 1'b1; c.asel = a;
        return c;
    endfunction
    function automatic ctrl_t cw_wr_reg();
        ctrl_t c = '0;
        c.nsel = 3'b010; c.vsel = 4'b1000; c.write = 1'b1; c.done = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t cw_wr_imm();
        ctrl_t c = '0;
        c.nsel = 3'b001; c.vsel = 4'b0010; c.write = 1'b1; c.done = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t cw_stat();
        ctrl_t c = '0;
        c.loads = 1'b1; c.done = 1'b1;
        return c;
    endfunction
    function automatic ctrl_t cw_halt();
        ctrl_t c = '0;
        c.illegal = 1'b1;
        return c;
    endfunction

    // Expected words for every cycle from DECODE up to (not including) the
    // return to WAIT. Returns 1 for a legal instruction.
    function automatic bit build_expected(input logic [2:0] opc, input logic [1:0] op);
        bit legal = 1'b1;
        exp_q.delete();
        exp_q.push_back(cw_decode());
        if (opc == 3'b110 && op == 2'b10) begin          // MOV Rn,#im8
            exp_q.push_back(cw_wr_imm());
        end else if (opc == 3'b110 && op == 2'b00) begin // MOV Rd,Rm
            exp_q.push_back(cw_get_b());
            exp_q.push_back(cw_alu(1'b1));
            exp_q.push_back(cw_wr_reg());
        end else if (opc == 3'b101 && op == 2'b01) begin // CMP
            exp_q.push_back(cw_get_a());
            exp_q.push_back(cw_get_b());
            exp_q.push_back(cw_stat());
        end else if (opc == 3'b101 && op == 2'b11) begin // MVN
            exp_q.push_back(cw_get_b());
            exp_q.push_back(cw_alu(1'b1));
            exp_q.push_back(cw_wr_reg());
        end else if (opc == 3'b101) begin                 // ADD / AND
            exp_q.push_back(cw_get_a());
            exp_q.push_back(cw_get_b());
            exp_q.push_back(cw_alu(1'b0));
            exp_q.push_back(cw_wr_reg());
        end else begin
            legal = 1'b0;
`ifdef CPU_ILLEGAL_TRAP_EN
            for (int k = 0; k < 10; k++) exp_q.push_back(cw_halt());
`endif
        end
        return legal;
    endfunction

    function automatic ctrl_t observe();
        ctrl_t c;
        c.w = bus.w; c.nsel = bus.nsel; c.vsel = bus.vsel;
        c.loada = bus.loada; c.loadb = bus.loadb; c.loadc = bus.loadc;
        c.loads = bus.loads; c.write = bus.write; c.asel = bus.asel;
        c.bsel = bus.bsel; c.done = bus.done; c.illegal = bus.illegal;
        return c;
    endfunction

    task automatic chk_ctrl(input string tag, input ctrl_t exp);
        ctrl_t obs;
        obs = observe();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
        logic [RW-1:0] e;
        e = RW'(model_icount);
        checks++;
        assert (bus.icount === e) else begin
            errors++;
            $error("FAIL %s: icount observed %0d expected %0d", tag, bus.icount, e);
        end
    endtask

    // Assert reset asynchronously between edges and hold it over one posedge
    // with s=1; release at the following negedge.
    task automatic async_reset(input string tag);
        #2 reset_n = 1'b0;
        bus.s = 1'b1;
        model_icount = 0;
        #1;
        chk_ctrl({tag, "_rst_now"}, cw_wait());
        chk_cnt({tag, "_rst_cnt"});
        @(negedge clk);
        chk_ctrl({tag, "_rst_held"}, cw_wait());
        reset_n = 1'b1;
        bus.s   = 1'b0;
    endtask

    // Called at a negedge with the controller idle. Issues one instruction
    // and checks every cycle; abort_at >= 0 resets after that step.
    task automatic run_instr(input string name, input logic [2:0] opc, input logic [1:0] op,
                             input int abort_at, input bit force110);
        bit legal;
        legal = build_expected(opc, op);
        chk_ctrl({name, "_idle"}, cw_wait());
        chk_cnt({name, "_idle_cnt"});
        bus.s = 1'b1; bus.opcode = opc; bus.op = op;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            bus.s      = 1'($urandom_range(0, 1));
            bus.opcode = force110 ? 3'b110 : 3'($urandom);
            bus.op     = 2'($urandom);
            chk_ctrl($sformatf("%s_step%0d", name, i), exp_q[i]);
            chk_cnt($sformatf("%s_cnt%0d", name, i));
            if (i == abort_at) begin
                async_reset(name);
                return;
            end
        end
        if (!legal) begin
`ifdef CPU_ILLEGAL_TRAP_EN
            async_reset(name);
            @(negedge clk);
            return;
`endif
        end else begin
            model_icount = (model_icount + 1) % (1 << RW);
        end
        bus.s = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle_cycles(input string tag, input int n);
        bus.s = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.opcode = 3'($urandom);
            bus.op     = 2'($urandom);
            chk_ctrl($sformatf("%s_%0d", tag, i), cw_wait());
        end
    endtask

    initial begin
        logic [2:0] ropc;
        logic [1:0] rop;
        checks = 0; errors = 0; model_icount = 0;
        reset_n = 1'b0; bus.s = 1'b0; bus.opcode = 3'b000; bus.op = 2'b00;
        repeat (2) @(negedge clk);
        chk_ctrl("reset_word", cw_wait());
        chk_cnt("reset_cnt");
        reset_n = 1'b1;
        idle_cycles("post_reset_idle", 3);

        run_instr("mov_imm", 3'b110, 2'b10, -1, 1'b0);
        run_instr("add",     3'b101, 2'b00, -1, 1'b1);
        run_instr("cmp",     3'b101, 2'b01, -1, 1'b0);
        run_instr("mvn",     3'b101, 2'b11, -1, 1'b0);
        run_instr("mov_reg", 3'b110, 2'b00, -1, 1'b0);
        run_instr("and",     3'b101, 2'b10, -1, 1'b0);

        // Reset during ADD while in GET_B (step index 2).
        run_instr("add_abort", 3'b101, 2'b00, 2, 1'b0);
        idle_cycles("abort_idle", 4);
        run_instr("after_abort", 3'b110, 2'b10, -1, 1'b0);

        run_instr("illegal111", 3'b111, 2'b00, -1, 1'b0);
        run_instr("after_illegal", 3'b101, 2'b01, -1, 1'b0);

        // Enough retirements to wrap the narrow counter.
        for (int n = 0; n < 20; n++) begin
            run_instr($sformatf("wrap%0d", n), 3'b110, 2'b10, -1, 1'b0);
        end

        for (int n = 0; n < 80; n++) begin
            ropc = 3'($urandom);
            rop  = 2'($urandom);
            if ($urandom_range(0, 3) == 0) ropc = 3'b101;
            run_instr($sformatf("rnd%0d", n), ropc, rop, -1, 1'b0);
            if ($urandom_range(0, 2) == 0) idle_cycles($sformatf("rnd_idle%0d", n), 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
